// File: rtl/mem_master_port_pkg.sv
// Shared definitions for the memory master port: default geometry, FSM encodings,
// requester ids and the out-of-bounds helper.
package mem_master_port_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_MEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_LS = 1'b1;

    // Full-width unsigned compare; addresses never wrap into the implemented range.
    function automatic logic is_oob(input logic [31:0] addr, input int unsigned depth);
        return (addr >= depth);
    endfunction

endpackage

// File: rtl/mem_master_port_arb2.sv
// Two-way fixed-priority combinational arbiter. req[1] wins ties when prio=1, req[0] otherwise.
module mem_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    // Priority select between the two requesters
    always_comb begin
        gnt = 2'b00;
        if (req[1] && (prio || !req[0])) begin
            gnt = 2'b10;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/mem_master_port.sv
// CPU-side initiator for the single-port memory: arbitrates fetch vs load/store,
// issues registered strobes and returns read data with a one-cycle valid pulse.
module mem_master_port
    import mem_master_port_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter bit LS_PRIORITY = 1'b1
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_in,
    input  logic [DATA_W-1:0] Data_out,
    output logic              busy,
    output logic              err_oob
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [1:0]        arb_gnt_s;
    logic              gnt_any_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic              sel_we_s;
    logic              sel_oob_s;
    logic              src_r;
    logic              we_r;
    logic              oob_r;
    logic [DATA_W-1:0] rd_word_s;

    mem_arb2 u_arb (
        .req  ({ls_req, if_req}),
        .prio (LS_PRIORITY),
        .gnt  (arb_gnt_s)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = gnt_any_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt_s = we_r ? ST_IDLE : ST_WAIT;
            ST_WAIT:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: grants only in IDLE and never while reset is asserted
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        busy   = 1'b1;
        if (state_r == ST_IDLE) begin
            if_gnt = arb_gnt_s[SRC_IF] & reset_n;
            ls_gnt = arb_gnt_s[SRC_LS] & reset_n;
            busy   = 1'b0;
        end else begin
            busy   = 1'b1;
        end
    end

    // Selected request attributes in the grant cycle
    always_comb begin
        gnt_any_s  = if_gnt | ls_gnt;
        sel_addr_s = ls_gnt ? ls_addr : if_addr;
        sel_we_s   = ls_gnt & ls_we;
        sel_oob_s  = is_oob(32'(sel_addr_s), MEM_DEPTH);
        rd_word_s  = oob_r ? {DATA_W{1'b0}} : Data_out;
    end

    // Transaction latch, memory-side registers and completion pulses
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            src_r     <= SRC_IF;
            we_r      <= 1'b0;
            oob_r     <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            ADDR      <= {ADDR_W{1'b0}};
            Data_in   <= {DATA_W{1'b0}};
            if_rvalid <= 1'b0;
            if_rdata  <= {DATA_W{1'b0}};
            ls_rvalid <= 1'b0;
            ls_done   <= 1'b0;
            ls_rdata  <= {DATA_W{1'b0}};
            err_oob   <= 1'b0;
        end else begin
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_done   <= 1'b0;
            err_oob   <= 1'b0;
            if (gnt_any_s) begin
                src_r    <= ls_gnt ? SRC_LS : SRC_IF;
                we_r     <= sel_we_s;
                oob_r    <= sel_oob_s;
                ADDR     <= sel_addr_s;
                MemRead  <= ~sel_we_s & ~sel_oob_s;
                MemWrite <= sel_we_s & ~sel_oob_s;
                if (sel_we_s) begin
                    Data_in <= ls_wdata;
                end
            end
            if ((state_r == ST_ISSUE) && we_r) begin
                ls_done <= 1'b1;
                err_oob <= oob_r;
            end
            // Data_out is valid the cycle after MemRead was sampled
            if (state_r == ST_WAIT) begin
                err_oob <= oob_r;
                if (src_r == SRC_LS) begin
                    ls_rdata  <= rd_word_s;
                    ls_rvalid <= 1'b1;
                end else begin
                    if_rdata  <= rd_word_s;
                    if_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_master_port.sv
// Directed bench for mem_master_port with a 1024x16 registered-read memory stub.
module tb_mem_master_port;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [15:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_done;
    logic [15:0] ls_addr, ls_wdata, ls_rdata;
    logic        MemRead, MemWrite, busy, err_oob;
    logic [15:0] ADDR, Data_in, Data_out;

    logic [15:0] mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    logic        both_strobes = 1'b0;
    logic [15:0] last_if = 16'h0000;
    logic [15:0] last_ls = 16'h0000;

    typedef struct {
        logic        is_ls;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        oob;
    } vec_t;

    vec_t vecs [0:11];

    always #5 CLK = ~CLK;

    mem_master_port dut (
        .CLK(CLK), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .ADDR(ADDR), .Data_in(Data_in), .Data_out(Data_out),
        .busy(busy), .err_oob(err_oob)
    );

    always @(posedge CLK) begin
        if (MemWrite) mem[ADDR[9:0]] <= Data_in;
        if (MemRead)  Data_out <= mem[ADDR[9:0]];
    end

    always @(negedge CLK) begin
        if (MemRead && MemWrite) both_strobes = 1'b1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_ctl"}, {6'b0, if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_done,
                             MemRead, MemWrite, busy, err_oob, 1'b0}, 16'h0000);
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int n;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge CLK);
        if (v.is_ls) begin
            ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        n = 0;
        while (!(v.is_ls ? ls_gnt : if_gnt) && n < 10) begin
            @(negedge CLK); #1; n++;
        end
        chk({tag, "_gnt"}, 16'(v.is_ls ? ls_gnt : if_gnt), 16'h0001);
        chk({tag, "_gnt_other"}, 16'(v.is_ls ? if_gnt : ls_gnt), 16'h0000);
        @(negedge CLK);
        if_req = 1'b0; ls_req = 1'b0;
        #1;
        chk({tag, "_MemRead"}, 16'(MemRead), 16'(!v.we && !v.oob));
        chk({tag, "_MemWrite"}, 16'(MemWrite), 16'(v.we && !v.oob));
        chk({tag, "_ADDR"}, ADDR, v.addr);
        if (v.we) chk({tag, "_Data_in"}, Data_in, v.wdata);
        chk({tag, "_busy1"}, 16'(busy), 16'h0001);
        @(negedge CLK); #1;
        chk({tag, "_strobes_off"}, {14'b0, MemRead, MemWrite}, 16'h0000);
        if (v.we) begin
            chk({tag, "_done"}, 16'(ls_done), 16'h0001);
            chk({tag, "_err_oob"}, 16'(err_oob), 16'(v.oob));
            chk({tag, "_busy_end"}, 16'(busy), 16'h0000);
        end else begin
            chk({tag, "_early_rvalid"}, {14'b0, if_rvalid, ls_rvalid}, 16'h0000);
            @(negedge CLK); #1;
            chk({tag, "_rvalid"}, {14'b0, if_rvalid, ls_rvalid}, v.is_ls ? 16'h0001 : 16'h0002);
            chk({tag, "_rdata"}, v.is_ls ? ls_rdata : if_rdata, v.rdata);
            chk({tag, "_err_oob"}, 16'(err_oob), 16'(v.oob));
            chk({tag, "_busy_end"}, 16'(busy), 16'h0000);
            if (v.is_ls) last_ls = v.rdata;
            else         last_if = v.rdata;
        end
        chk({tag, "_hold_if"}, if_rdata, last_if);
        chk({tag, "_hold_ls"}, ls_rdata, last_ls);
    endtask

    initial begin
        int g, rv, prev;
        logic upd;

        for (int i = 0; i < 1024; i++) mem[i] = 16'hA000 | 16'(i);
        Data_out = 16'h0000;
        reset_n = 1'b0;
        if_req = 1'b0; if_addr = 16'h0000;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 16'h0000; ls_wdata = 16'h0000;

        //               is_ls we    addr      wdata     rdata     oob
        vecs[0]  = '{1'b1, 1'b1, 16'h001E, 16'h001F, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h001E, 16'h0000, 16'h001F, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hA000, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'hA003, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 16'h0400, 16'hBEEF, 16'h0000, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 16'hA3FF, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 16'h03FF, 16'h1234, 16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 16'h1234, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h03FF, 16'h0000, 16'h1234, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA000, 1'b0};

        repeat (3) @(negedge CLK);
        #1;
        chk_quiet("reset");
        chk("reset_ADDR", ADDR, 16'h0000);
        chk("reset_rdata", if_rdata | ls_rdata | Data_in, 16'h0000);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) run_txn(vecs[i], i);

        // Simultaneous requests: load/store wins, fetch granted in the ls_rvalid cycle
        @(negedge CLK);
        if_req = 1'b1; if_addr = 16'h0000;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h001E;
        #1;
        chk("prio_ls_gnt", {14'b0, ls_gnt, if_gnt}, 16'h0002);
        @(negedge CLK); ls_req = 1'b0; #1;
        chk("prio_if_wait", 16'(if_gnt), 16'h0000);
        @(negedge CLK); #1;
        chk("prio_if_wait2", 16'(if_gnt), 16'h0000);
        @(negedge CLK); #1;
        chk("prio_ls_rvalid", 16'(ls_rvalid), 16'h0001);
        chk("prio_ls_rdata", ls_rdata, 16'h001F);
        chk("prio_if_gnt", 16'(if_gnt), 16'h0001);
        last_ls = 16'h001F;
        @(negedge CLK); if_req = 1'b0;
        @(negedge CLK);
        @(negedge CLK); #1;
        chk("prio_if_rvalid", 16'(if_rvalid), 16'h0001);
        chk("prio_if_rdata", if_rdata, 16'hA000);

        // Back-to-back fetches with if_req held
        @(negedge CLK);
        if_req = 1'b1; if_addr = 16'h0000;
        g = 0; rv = 0; prev = 0; upd = 1'b0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (if_rvalid) begin
                chk($sformatf("b2b_rdata%0d", rv), if_rdata, 16'hA000 | 16'(rv));
                rv++;
            end
            if (if_gnt) begin
                if (g > 0) chk($sformatf("b2b_gap%0d", g), 16'(c - prev), 16'd3);
                prev = c;
                g++;
                upd = 1'b1;
            end
            @(negedge CLK);
            if (upd) begin
                upd = 1'b0;
                if (g < 4) if_addr = 16'(g);
                else       if_req = 1'b0;
            end
        end
        chk("b2b_grants", 16'(g), 16'd4);
        chk("b2b_rvalids", 16'(rv), 16'd4);
        last_if = 16'hA003;

        // Reset while a fetch is waiting for read data
        @(negedge CLK);
        if_req = 1'b1; if_addr = 16'h0001;
        #1;
        chk("rst_fetch_gnt", 16'(if_gnt), 16'h0001);
        @(negedge CLK); if_req = 1'b0; #1;
        chk("rst_fetch_MemRead", 16'(MemRead), 16'h0001);
        @(negedge CLK); #1;
        chk("rst_in_wait_busy", 16'(busy), 16'h0001);
        reset_n = 1'b0;
        #1;
        chk_quiet("rst_mid");
        chk("rst_mid_data", if_rdata | ls_rdata | ADDR | Data_in, 16'h0000);
        last_if = 16'h0000; last_ls = 16'h0000;
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK); #1;
            chk($sformatf("rst_release%0d", c), {14'b0, if_rvalid, MemRead}, 16'h0000);
        end
        run_txn('{1'b0, 1'b0, 16'h0001, 16'h0000, 16'hA001, 1'b0}, 99);

        chk("strobes_exclusive", 16'(both_strobes), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
